decay_scheduler: RTL and testbench

DECAY_SCHEDULER -- requirements
Module: decay_scheduler

---
 rtl/decay_sched_pkg.sv | 47 ++++
 rtl/decay_scheduler_if.sv | 22 ++
 rtl/fp_exp_shift.sv | 31 +++
 rtl/decay_scheduler.sv | 143 ++++++++++++++
 tb/tb_decay_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decay_sched_pkg.sv
// Shared types and constants for the decay scheduler:
// FSM states, rate codes, LIF model code and FP32 field positions.
package decay_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_COMPUTE,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [3:0] RATE_SH0 = 4'b0001;
  localparam logic [3:0] RATE_SH1 = 4'b0010;
  localparam logic [3:0] RATE_SH2 = 4'b0100;
  localparam logic [3:0] RATE_SH3 = 4'b1000;

  localparam logic [1:0] MODEL_LIF = 2'b00;

  localparam int FP_SIGN   = 31;
  localparam int FP_EXP_HI = 30;
  localparam int FP_EXP_LO = 23;

  typedef struct packed {
    logic [3:0] rate;
    logic [1:0] model;
  } nrn_cfg_t;

  localparam nrn_cfg_t CFG_RST = '{
    rate:  RATE_SH0,
    model: MODEL_LIF
  };

  function automatic logic [1:0] rate_shift(
    input logic [3:0] r
  );
    logic [1:0] s;
    case (r)
      RATE_SH1: s = 2'd1;
      RATE_SH2: s = 2'd2;
      RATE_SH3: s = 2'd3;
      default:  s = 2'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/decay_scheduler_if.sv
// Potential-memory request/ack bus between the
// decay scheduler (master) and the memory (slave).
interface decay_scheduler_if #(
  parameter int ADDR_W = 12
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/fp_exp_shift.sv
// FP32 exponent decrement; zero/denormal and inf/NaN pass through.
// DECAY_UNDERFLOW_CLAMP_EN: flush to signed zero instead of wrapping.
module fp_exp_shift
  import decay_sched_pkg::*;
(
  input  logic [31:0] in,
  input  logic [1:0]  shift,
  output logic [31:0] out
);

  logic [7:0] exp_v;
  logic [7:0] sh_v;

  assign exp_v = in[FP_EXP_HI:FP_EXP_LO];
  assign sh_v  = {6'd0, shift};

  always_comb begin
    out = in;
    if (exp_v != 8'h00 && exp_v != 8'hFF) begin
`ifdef DECAY_UNDERFLOW_CLAMP_EN
      if (exp_v <= sh_v)
        out = {in[FP_SIGN], 31'd0};
      else
        out[FP_EXP_HI:FP_EXP_LO] = exp_v - sh_v;
`else
      out[FP_EXP_HI:FP_EXP_LO] = exp_v - sh_v;
`endif
    end
  end

endmodule

// File: rtl/decay_scheduler.sv
// Per-timestep sweep decaying each LIF neuron's FP32 potential.
// Optional DECAY_UNDERFLOW_CLAMP_EN selects clamped underflow.
module decay_scheduler
  import decay_sched_pkg::*;
#(
  parameter int NEURONS = 30,
  parameter int ADDR_W  = 12
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              timestep,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [3:0]        cfg_rate,
  input  logic [1:0]        cfg_model,
  decay_scheduler_if.master mem,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  nrn_cfg_t          tbl_q [NEURONS];
  nrn_cfg_t          tbl_d [NEURONS];
  nrn_cfg_t          ent_q, ent_d;
  nrn_cfg_t          tbl_rd, cur;
  logic              first_q, first_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              overrun_q, overrun_d;
  logic [31:0]       decayed;
  logic              last, lif;

  always_comb begin
    tbl_rd = CFG_RST;
    for (int i = 0; i < NEURONS; i++)
      if (addr_q == ADDR_W'(i))
        tbl_rd = tbl_q[i];
  end

  // Entry is sampled on a neuron's first READ cycle and held after.
  assign cur  = first_q ? tbl_rd : ent_q;
  assign lif  = (cur.model == MODEL_LIF);
  assign last = (addr_q == ADDR_W'(NEURONS - 1));

  fp_exp_shift u_shift (
    .in    (rdata_q),
    .shift (rate_shift(ent_q.rate)),
    .out   (decayed)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tbl_d     = tbl_q;
    ent_d     = ent_q;
    first_d   = 1'b0;
    rdata_d   = rdata_q;
    wdata_d   = wdata_q;
    overrun_d = timestep && (state_q != S_IDLE);

    for (int i = 0; i < NEURONS; i++)
      if (cfg_we && cfg_addr == ADDR_W'(i))
        tbl_d[i] = '{rate: cfg_rate, model: cfg_model};

    unique case (state_q)
      S_IDLE: begin
        if (timestep) begin
          addr_d  = '0;
          first_d = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        ent_d = cur;
        if (!lif) begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            first_d = 1'b1;
          end
        end else if (mem.mem_ack) begin
          rdata_d = mem.mem_rdata;
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        wdata_d = decayed;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (mem.mem_ack) begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            first_d = 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      tbl_q     <= '{default: CFG_RST};
      ent_q     <= CFG_RST;
      first_q   <= 1'b0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tbl_q     <= tbl_d;
      ent_q     <= ent_d;
      first_q   <= first_d;
      rdata_q   <= rdata_d;
      wdata_q   <= wdata_d;
      overrun_q <= overrun_d;
    end
  end

  assign mem.mem_req   = (state_q == S_READ && lif) ||
                         (state_q == S_WRITE);
  assign mem.mem_we    = (state_q == S_WRITE);
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign busy    = (state_q == S_READ) ||
                   (state_q == S_COMPUTE) ||
                   (state_q == S_WRITE);
  assign done    = (state_q == S_DONE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_decay_scheduler.sv
// Bench for decay_scheduler: memory responder with programmable
// ack delay, access log, and a spec-level decay/latency model.
module tb_decay_scheduler;

  localparam int N  = 4;
  localparam int AW = 12;

  logic          CLK = 1'b0;
  logic          reset;
  logic          timestep;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [3:0]    cfg_rate;
  logic [1:0]    cfg_model;
  logic          busy, done, overrun;

  decay_scheduler_if #(.ADDR_W(AW)) bus ();

  decay_scheduler #(.NEURONS(N), .ADDR_W(AW)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .timestep  (timestep),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_rate  (cfg_rate),
    .cfg_model (cfg_model),
    .mem       (bus),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          we;
    int          addr;
    logic [31:0] data;
  } acc_t;

  logic [31:0]   mem_arr [N];
  acc_t          log_q [$];
  int            ack_delay = 0;
  int            wcnt = 0;
  bit            stray_ack = 1'b0;
  int            unstable = 0;
  bit            prev_wait = 1'b0;
  logic [AW-1:0] prev_addr;
  logic          prev_we;
  logic [31:0]   prev_wd;

  assign bus.mem_ack = (bus.mem_req && wcnt >= ack_delay) || stray_ack;
  assign bus.mem_rdata = mem_arr[bus.mem_addr[1:0]];

  always @(posedge CLK) begin
    if (bus.mem_req && bus.mem_ack) begin
      log_q.push_back('{bus.mem_we, int'(bus.mem_addr), bus.mem_wdata});
      wcnt <= 0;
    end else if (bus.mem_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
    if (prev_wait && (!bus.mem_req || bus.mem_addr != prev_addr ||
        bus.mem_we != prev_we || bus.mem_wdata != prev_wd))
      unstable <= unstable + 1;
    prev_wait <= bus.mem_req && !bus.mem_ack;
    prev_addr <= bus.mem_addr;
    prev_we   <= bus.mem_we;
    prev_wd   <= bus.mem_wdata;
  end

  logic [3:0] m_rate [N];
  logic [1:0] m_model [N];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] ref_decay(input logic [31:0] x,
                                            input logic [3:0] rate);
    int sh;
    int e;
    case (rate)
      4'b0001: sh = 0;
      4'b0010: sh = 1;
      4'b0100: sh = 2;
      4'b1000: sh = 3;
      default: sh = 0;
    endcase
    e = int'(x[30:23]);
    if (e == 0 || e == 255) return x;
`ifdef DECAY_UNDERFLOW_CLAMP_EN
    if (e <= sh) return {x[31], 31'd0};
`endif
    e = (e - sh + 256) % 256;
    return {x[31], 8'(e), x[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 5))
      0: x[30:23] = 8'h00;
      1: x[30:23] = 8'hFF;
      2: x[30:23] = 8'($urandom_range(1, 3));
      default: ;
    endcase
    return x;
  endfunction

  task automatic cfg_write(input int n, input logic [3:0] r,
                           input logic [1:0] m);
    cfg_we = 1'b1;
    cfg_addr = AW'(n);
    cfg_rate = r;
    cfg_model = m;
    tick();
    cfg_we = 1'b0;
    if (n < N) begin
      m_rate[n] = r;
      m_model[n] = m;
    end
  endtask

  task automatic model_defaults();
    for (int i = 0; i < N; i++) begin
      m_rate[i] = 4'b0001;
      m_model[i] = 2'b00;
    end
  endtask

  // One sweep; optional mid-sweep timestep (ovr_at) and cfg write (cfg_at).
  task automatic sweep(input int dly, input int ovr_at, input int cfg_at,
                       input int cfg_n, input logic [3:0] cfg_r,
                       input logic [1:0] cfg_m, output int base);
    int cyc;
    int exp_t;
    int ub;
    acc_t eq [$];
    ack_delay = dly;
    base = log_q.size();
    ub = unstable;
    timestep = 1'b1;
    tick();
    timestep = 1'b0;
    chk("busy_start", busy, 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 500) begin
      timestep = (cyc == ovr_at);
      cfg_we = (cyc == cfg_at);
      if (cyc == cfg_at) begin
        cfg_addr = AW'(cfg_n);
        cfg_rate = cfg_r;
        cfg_model = cfg_m;
        if (cfg_n < N) begin
          m_rate[cfg_n] = cfg_r;
          m_model[cfg_n] = cfg_m;
        end
      end
      tick();
      timestep = 1'b0;
      cfg_we = 1'b0;
      cyc++;
      if (ovr_at >= 0 && cyc == ovr_at + 1) chk("overrun_hi", overrun, 1);
      if (ovr_at >= 0 && cyc == ovr_at + 2) chk("overrun_lo", overrun, 0);
    end
    exp_t = 0;
    for (int i = 0; i < N; i++) begin
      if (m_model[i] == 2'b00) begin
        exp_t += 3 + 2 * dly;
        eq.push_back('{1'b0, i, 32'd0});
        eq.push_back('{1'b1, i, ref_decay(mem_arr[i], m_rate[i])});
      end else begin
        exp_t += 1;
      end
    end
    chk("done_seen", done, 1);
    chk("latency", cyc, exp_t);
    chk("busy_at_done", busy, 0);
    chk("overrun_quiet", overrun, 0);
    chk("stable", unstable - ub, 0);
    chk("acc_count", log_q.size() - base, eq.size());
    for (int k = 0; k < eq.size(); k++) begin
      if (base + k < log_q.size()) begin
        chk("acc_we", log_q[base + k].we, eq[k].we);
        chk("acc_addr", log_q[base + k].addr, eq[k].addr);
        if (eq[k].we) chk("acc_wdata", log_q[base + k].data, eq[k].data);
      end
    end
    tick();
    chk("done_pulse", done, 0);
  endtask

  initial begin
    int b;
    int w;
    int nlog;
    logic [3:0] rpool [8];
    rpool = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
              4'b0011, 4'b0000, 4'b1111, 4'b0101};
    reset = 1'b1;
    timestep = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_rate = '0;
    cfg_model = '0;
    for (int i = 0; i < N; i++) mem_arr[i] = 32'd0;
    model_defaults();
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    reset = 1'b0;
    tick();

    nlog = log_q.size();
    stray_ack = 1'b1;
    repeat (3) tick();
    stray_ack = 1'b0;
    chk("stray_req", bus.mem_req, 0);
    chk("stray_busy", busy, 0);
    chk("stray_log", log_q.size(), nlog);

    for (int i = 0; i < N; i++) mem_arr[i] = rnd_fp();
    mem_arr[0] = 32'h41DED852;
    cfg_write(0, 4'b0010, 2'b00);
    sweep(0, -1, -1, 0, 0, 0, b);
    chk("req030", log_q[b + 1].data, 32'h415ED852);

    mem_arr[0] = 32'h41DED852;
    mem_arr[1] = 32'h41DED852;
    cfg_write(0, 4'b1000, 2'b00);
    cfg_write(1, 4'b0011, 2'b00);
    sweep(1, -1, -1, 0, 0, 0, b);
    chk("req031_r8", log_q[b + 1].data, 32'h405ED852);
    chk("req031_r3", log_q[b + 3].data, 32'h41DED852);

    mem_arr[0] = 32'h01000000;
    sweep(0, -1, -1, 0, 0, 0, b);
`ifdef DECAY_UNDERFLOW_CLAMP_EN
    chk("req032", log_q[b + 1].data, 32'h00000000);
`else
    chk("req032", log_q[b + 1].data, 32'h7F800000);
`endif

    for (int i = 0; i < N; i++) mem_arr[i] = rnd_fp();
    cfg_write(1, 4'b0100, 2'b01);
    cfg_write(3, 4'b0100, 2'b01);
    cfg_write(7, 4'b1000, 2'b11);
    sweep(1, -1, -1, 0, 0, 0, b);

    for (int i = 0; i < N; i++) mem_arr[i] = rnd_fp();
    sweep(2, 2, 1, 3, 4'b0100, 2'b00, b);

    for (int i = 0; i < N; i++) mem_arr[i] = rnd_fp();
    sweep(5, -1, -1, 0, 0, 0, b);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) begin
        mem_arr[i] = rnd_fp();
        cfg_write(i, rpool[$urandom_range(0, 7)],
                  ($urandom_range(0, 3) == 0) ?
                  2'($urandom_range(1, 3)) : 2'b00);
      end
      sweep($urandom_range(0, 3), -1, -1, 0, 0, 0, b);
    end

    ack_delay = 5;
    timestep = 1'b1;
    tick();
    timestep = 1'b0;
    w = 0;
    while (!(bus.mem_req && bus.mem_we) && w < 200) begin
      tick();
      w++;
    end
    chk("reach_write", bus.mem_req & bus.mem_we, 1);
    nlog = log_q.size();
    reset = 1'b1;
    tick();
    chk("rstmid_req", bus.mem_req, 0);
    chk("rstmid_busy", busy, 0);
    reset = 1'b0;
    repeat (4) tick();
    chk("rstmid_req_idle", bus.mem_req, 0);
    chk("rstmid_log", log_q.size(), nlog);
    model_defaults();
    for (int i = 0; i < N; i++) mem_arr[i] = rnd_fp();
    sweep(0, -1, -1, 0, 0, 0, b);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
